ethermac_tx_feeder: RTL and testbench
=====================================

# ethermac_tx_feeder

Ping-pong frame buffer between the DHCP/packet builder and the MII transmit engine. It accepts a frame as a stream of 16-bit words and stores it in one of two banks. It pads short frames to the Ethernet minimum, drops oversize frames, and launches the transmit engine with a one-cycle send request plus word length. While the engine fetches words by address, the other bank can be filled.

## Interface
- `MAX_WORDS`, 757: largest accepted frame in 16-bit words; must not exceed 1023.
- `MIN_WORDS`, 30: minimum reported length (60 bytes); shorter frames are zero-padded.
- `BANK_DEPTH`, 1024: words per bank.
- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_wr_valid`  in  1  upstream word valid.
- `i_wr_data`  in  16  frame word; byte order as consumed by the transmit engine (low byte sent first).
- `i_wr_last`  in  1  marks final word of frame; qualified by `i_wr_valid`.
- `o_wr_ready`  out  1  word accepted on the edge where valid&ready.
- `o_SendIrq`  out  1  one-cycle send request to transmit engine.
- `o_length`  out  10  frame length in words; stable from the `o_SendIrq` cycle until `i_sendDn`.
- `i_data_addr`  in  10  word address driven by transmit engine.
- `o_data`  out  16  combinational read of the sending bank at `i_data_addr`.
- `i_sendDn`  in  1  one-cycle frame-complete pulse from engine.
- `i_sendIdl`  in  1  engine idle indication.
- `o_drop`  out  1  one-cycle pulse: oversize frame discarded.
- `o_busy`  out  1  high while any bank is FULL or SENDING.

## Operation
- **Per-bank state:** EMPTY, FILLING, FULL, SENDING. Each bank also holds a word count `cnt[9:0]`.
- **Write side:**
  - Register `wr_bank` selects the fill bank and resets to 0.
  - `o_wr_ready` = fill bank is EMPTY or FILLING.
  - Each accepted word is written at address `cnt`, then `cnt` increments and the bank becomes FILLING.
- **Oversize frames:**
  - An accepted word with `cnt == MAX_WORDS` sets the `ovf` flag. That word and all later words are discarded, but still accepted.
  - On the accepted last word with `ovf` set: pulse `o_drop` the next cycle, set `cnt` to 0, return the bank to EMPTY, clear `ovf`. `wr_bank` does not toggle.
- **Commit:**
  - On the accepted last word with `ovf` clear: the bank becomes FULL, its `cnt` includes the last word, and `wr_bank` toggles.
  - Frames are therefore committed alternately, bank 0 then bank 1.
- **Send side FSM:**
  - **S_IDLE:** if bank `rd_bank` is FULL and `i_sendIdl`=1, go to S_IRQ.
  - **S_IRQ:** assert `o_SendIrq` for exactly one cycle. Latch `o_length = max(cnt, MIN_WORDS)`. Mark the bank SENDING. Go to S_WAIT.
  - **S_WAIT:** hold until `i_sendDn`=1, then go to S_GAP. On `i_sendDn`, release the bank to EMPTY with `cnt=0` and toggle `rd_bank`.
  - **S_GAP:** wait one cycle, then return to S_IDLE. This guarantees no request lands while the engine exits its done state.
- **Read data:** `o_data = (i_data_addr < cnt[rd_bank]) ? mem[rd_bank][i_data_addr] : 16'h0000`, evaluated on the bank being sent. Addresses from `cnt` up to `o_length-1` therefore return zero padding.
- **Simultaneous events:**
  - A commit into bank A and the release of bank B on the same edge are both honoured.
  - A write into a bank being released is impossible, because `o_wr_ready` is low while the fill bank is FULL/SENDING.
- **Reset mid-operation:** all banks go EMPTY, all counters and flags clear, and the frames in flight are lost. Memory contents need no reset.

## Timing
- **Reset values:** `o_wr_ready`=1, `o_SendIrq`=0, `o_length`=0, `o_drop`=0, `o_busy`=0, send FSM in S_IDLE, `wr_bank`=`rd_bank`=0.
- **Latency:** last word accepted at edge N → bank FULL after edge N → `o_SendIrq` high in cycle N+2, provided the FSM is in S_IDLE with `i_sendIdl`=1.
- **Read path:** `o_data` is combinational from `i_data_addr`, with zero cycles of latency, because the engine captures the word in the same cycle it presents the address.
- **Back-to-back frames:** minimum spacing from one `i_sendDn` to the next `o_SendIrq` is 3 cycles (S_WAIT→S_GAP→S_IDLE→S_IRQ).
- **Back-pressure:** `o_wr_ready` deasserts in the cycle after the second bank becomes FULL while the first is still SENDING. It reasserts the cycle after the `i_sendDn` that frees a bank.

## Test plan
- **Single 40-word frame** (words 0x0001..0x0028): `o_SendIrq` pulses once with `o_length`=40. `o_data` at addr 0 = 0x0001 and at addr 39 = 0x0028. After `i_sendDn`: `o_busy`=0, `o_wr_ready`=1.
- **Short 10-word frame:** `o_length`=30. Addr 9 returns word 10. Addrs 10..29 return 0x0000.
- **Oversize 800-word frame:** no `o_SendIrq`. `o_drop` pulses once, one cycle after the last word. A following 40-word frame then goes out from bank 0 with `o_length`=40.
- **Three 40-word frames back-to-back**, engine holds `i_sendDn` off for 200 cycles:
  - `o_wr_ready` drops after frame 2 commits.
  - Frame 3 stalls until the first `i_sendDn`.
  - `o_SendIrq` pulses appear in order bank 0, 1, 0.
  - Each `o_SendIrq` occurs ≥3 cycles after the preceding `i_sendDn`.
- **`i_sendIdl`=0 held with bank 0 FULL:** no `o_SendIrq`. When `i_sendIdl` rises, `o_SendIrq` appears the next cycle.
- **`i_rst_n` asserted during S_WAIT:** all outputs return to their reset values immediately. A new frame after reset is sent from bank 0.

Source files
------------

// File: rtl/ethermac_tx_feeder.sv
// Two-bank ping-pong frame buffer feeding the MII transmit engine: the builder
// fills one bank while the engine reads the other by address.
module ethermac_tx_feeder #(
  parameter int MAX_WORDS  = 757,
  parameter int MIN_WORDS  = 30,
  parameter int BANK_DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_valid,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_last,
  output logic        o_wr_ready,
  output logic        o_SendIrq,
  output logic [9:0]  o_length,
  input  logic [9:0]  i_data_addr,
  output logic [15:0] o_data,
  input  logic        i_sendDn,
  input  logic        i_sendIdl,
  output logic        o_drop,
  output logic        o_busy
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_SENDING} bank_state_t;
  typedef enum logic [1:0] {S_IDLE, S_IRQ, S_WAIT, S_GAP} send_state_t;

  localparam logic [9:0] MAX_CNT = 10'(MAX_WORDS);
  localparam logic [9:0] MIN_CNT = 10'(MIN_WORDS);

  bank_state_t bank_state [2];
  logic [9:0]  cnt [2];
  logic        wr_bank;
  logic        rd_bank;
  logic        ovf;
  send_state_t state;
  send_state_t state_next;
  logic [15:0] mem [2][BANK_DEPTH];

  logic       wr_fire;
  logic       discard;
  logic       release_bank;
  logic [9:0] pad_len;

  assign wr_fire      = i_wr_valid & o_wr_ready;
  // Once a frame reaches MAX_WORDS, this and every later word is swallowed.
  assign discard      = ovf | (cnt[wr_bank] == MAX_CNT);
  assign release_bank = (state == S_WAIT) & i_sendDn;
  assign pad_len      = (cnt[rd_bank] < MIN_CNT) ? MIN_CNT : cnt[rd_bank];

  // NOTE: frame storage carries no reset; the per-bank counters already mark
  // which words are valid, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (wr_fire && !discard) mem[wr_bank][cnt[wr_bank]] <= i_wr_data;
  end

  // NOTE: all state below uses non-blocking assignments so the write side and
  // the send side can touch different banks on the same edge without ordering hazards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= B_EMPTY;
        cnt[b]        <= '0;
      end
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      ovf      <= 1'b0;
      o_drop   <= 1'b0;
      o_length <= '0;
    end else begin
      o_drop <= 1'b0;
      if (wr_fire) begin
        if (i_wr_last && discard) begin
          bank_state[wr_bank] <= B_EMPTY;
          cnt[wr_bank]        <= '0;
          ovf                 <= 1'b0;
          o_drop              <= 1'b1;
        end else if (i_wr_last) begin
          bank_state[wr_bank] <= B_FULL;
          cnt[wr_bank]        <= cnt[wr_bank] + 10'd1;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= B_FILLING;
          if (discard) ovf <= 1'b1;
          else         cnt[wr_bank] <= cnt[wr_bank] + 10'd1;
        end
      end
      // Length is captured on entry to S_IRQ so it is already valid while the request is high.
      if (state == S_IDLE && state_next == S_IRQ) o_length <= pad_len;
      if (state == S_IRQ) bank_state[rd_bank] <= B_SENDING;
      if (release_bank) begin
        bank_state[rd_bank] <= B_EMPTY;
        cnt[rd_bank]        <= '0;
        rd_bank             <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (bank_state[rd_bank] == B_FULL && i_sendIdl) state_next = S_IRQ;
      S_IRQ:  state_next = S_WAIT;
      S_WAIT: if (i_sendDn) state_next = S_GAP;
      S_GAP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_SendIrq  = (state == S_IRQ);
    o_wr_ready = (bank_state[wr_bank] == B_EMPTY) || (bank_state[wr_bank] == B_FILLING);
    o_busy     = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (bank_state[b] == B_FULL || bank_state[b] == B_SENDING) o_busy = 1'b1;
    end
    // Addresses past the stored words read as zero, which forms the minimum-length padding.
    o_data = 16'h0000;
    if (i_data_addr < cnt[rd_bank]) o_data = mem[rd_bank][i_data_addr];
  end

endmodule

// File: tb/tb_ethermac_tx_feeder.sv
// Bench for ethermac_tx_feeder: table-driven frames, randomized frames checked
// against a frame-queue reference model, and hand-written corner sequences.
module tb_ethermac_tx_feeder;

  localparam int MAX_WORDS = 757;
  localparam int MIN_WORDS = 30;
  localparam int BUDGET    = 20000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wr_valid;
  logic [15:0] i_wr_data;
  logic        i_wr_last;
  logic        o_wr_ready;
  logic        o_SendIrq;
  logic [9:0]  o_length;
  logic [9:0]  i_data_addr;
  logic [15:0] o_data;
  logic        i_sendDn;
  logic        i_sendIdl;
  logic        o_drop;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  ethermac_tx_feeder #(.MAX_WORDS(MAX_WORDS), .MIN_WORDS(MIN_WORDS), .BANK_DEPTH(1024)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .i_wr_last(i_wr_last), .o_wr_ready(o_wr_ready), .o_SendIrq(o_SendIrq),
    .o_length(o_length), .i_data_addr(i_data_addr), .o_data(o_data),
    .i_sendDn(i_sendDn), .i_sendIdl(i_sendIdl), .o_drop(o_drop), .o_busy(o_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: a queue (ring) of frames expected on the transmit side.
  logic [15:0] ring_words [4][1024];
  int ring_raw [4];
  int ring_len [4];
  int head = 0;
  int tail = 0;
  logic [15:0] fbuf [1024];

  bit auto_engine = 1'b1;
  bit engine_busy = 1'b0;
  int hold_cycles = 2;
  int irq_seen = 0;
  int drops_seen = 0;
  int last_len = 0;
  int dn_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int ref_length(input int raw);
    return (raw < MIN_WORDS) ? MIN_WORDS : raw;
  endfunction

  always @(negedge i_clk) if (o_drop === 1'b1) drops_seen <= drops_seen + 1;

  // Transmit engine: reacts to each send request, reads the whole frame back
  // against the model, holds for hold_cycles, then pulses done.
  initial begin
    int slot;
    int len;
    i_sendDn    = 1'b0;
    i_data_addr = '0;
    forever begin
      @(negedge i_clk);
      if (auto_engine && o_SendIrq === 1'b1) begin
        engine_busy = 1'b1;
        irq_seen++;
        last_len = 32'(o_length);
        if (dn_log.size() > 0) check("irq_gap_ge3", 32'((cyc - dn_log[dn_log.size()-1]) >= 3), 32'd1);
        if (head == tail) begin
          fail_now("irq_unexpected");
        end else begin
          slot = head % 4;
          len  = ring_len[slot];
          check("length", 32'(o_length), len);
          for (int a = 0; a < len; a++) begin
            i_data_addr = 10'(a);
            #1;
            check("data", 32'(o_data), (a < ring_raw[slot]) ? 32'(ring_words[slot][a]) : 32'd0);
            @(negedge i_clk);
          end
          check("length_hold", 32'(o_length), len);
          check("busy_sending", 32'(o_busy), 32'd1);
          head++;
        end
        repeat (hold_cycles) @(negedge i_clk);
        i_sendDn = 1'b1;
        dn_log.push_back(cyc);
        @(negedge i_clk);
        i_sendDn    = 1'b0;
        engine_busy = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [15:0] d, input bit last, output int acc);
    int b;
    b = 0;
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    i_wr_last  = last;
    while (o_wr_ready !== 1'b1 && b < BUDGET) begin
      @(negedge i_clk);
      b++;
    end
    if (b >= BUDGET) fail_now("wr_ready_timeout");
    acc = cyc;
    @(negedge i_clk);
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic push_frame(input int len, input bit gaps, output int first_acc);
    int acc;
    int slot;
    first_acc = 0;
    if (len <= MAX_WORDS) begin
      slot = tail % 4;
      ring_raw[slot] = len;
      ring_len[slot] = ref_length(len);
      for (int i = 0; i < len; i++) ring_words[slot][i] = fbuf[i];
      tail++;
    end
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge i_clk);
      push_word(fbuf[i], i == len - 1, acc);
      if (i == 0) first_acc = acc;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((head != tail || engine_busy) && b < BUDGET) begin
      @(negedge i_clk);
      b++;
    end
    if (b >= BUDGET) fail_now("drain_timeout");
    @(negedge i_clk);
  endtask

  typedef struct {
    int len;
    int hold;
    bit gaps;
    bit exp_drop;
    int exp_length;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int irq0, drop0, acc, k, first3, exp_irqs, exp_drops, len;

    tbl[0] = '{40,  5, 1'b0, 1'b0, 40};
    tbl[1] = '{10,  3, 1'b0, 1'b0, 30};
    tbl[2] = '{800, 0, 1'b0, 1'b1, 0};
    tbl[3] = '{40,  2, 1'b0, 1'b0, 40};
    tbl[4] = '{30,  1, 1'b1, 1'b0, 30};
    tbl[5] = '{29,  0, 1'b0, 1'b0, 30};
    tbl[6] = '{757, 1, 1'b0, 1'b0, 757};
    tbl[7] = '{758, 0, 1'b0, 1'b1, 0};
    tbl[8] = '{1,   4, 1'b0, 1'b0, 30};
    tbl[9] = '{31,  0, 1'b1, 1'b0, 31};

    i_rst_n    = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
    i_wr_last  = 1'b0;
    i_sendIdl  = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready",  32'(o_wr_ready), 32'd1);
    check("rst_irq",    32'(o_SendIrq),  32'd0);
    check("rst_length", 32'(o_length),   32'd0);
    check("rst_drop",   32'(o_drop),     32'd0);
    check("rst_busy",   32'(o_busy),     32'd0);

    // Table-driven frames
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < tbl[v].len; i++) fbuf[i] = (v < 2) ? 16'(i + 1) : 16'($urandom);
      irq0 = irq_seen;
      drop0 = drops_seen;
      hold_cycles = tbl[v].hold;
      push_frame(tbl[v].len, tbl[v].gaps, acc);
      if (tbl[v].exp_drop) begin
        check("drop_pulse", 32'(o_drop), 32'd1);
        @(negedge i_clk);
        check("drop_once", 32'(o_drop), 32'd0);
      end
      drain();
      check("irq_count",  irq_seen - irq0,    tbl[v].exp_drop ? 32'd0 : 32'd1);
      check("drop_count", drops_seen - drop0, tbl[v].exp_drop ? 32'd1 : 32'd0);
      if (!tbl[v].exp_drop) check("length_tbl", last_len, tbl[v].exp_length);
      check("busy_after",  32'(o_busy),     32'd0);
      check("ready_after", 32'(o_wr_ready), 32'd1);
    end

    // Three back-to-back frames with a slow engine: back-pressure and stall
    hold_cycles = 200;
    irq0 = irq_seen;
    k = dn_log.size();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 40; i++) fbuf[i] = 16'($urandom);
      push_frame(40, 1'b0, acc);
      if (f == 0) first3 = 0;
      if (f == 1) begin
        check("bp_ready_low", 32'(o_wr_ready), 32'd0);
        check("bp_busy",      32'(o_busy),     32'd1);
      end
      if (f == 2) first3 = acc;
    end
    if (dn_log.size() > k) check("f3_after_first_dn", first3, dn_log[k] + 1);
    else fail_now("f3_no_dn");
    drain();
    check("b2b_irq_count", irq_seen - irq0, 32'd3);
    hold_cycles = 2;

    // Randomized frames against the reference model
    irq0 = irq_seen;
    drop0 = drops_seen;
    exp_irqs = 0;
    exp_drops = 0;
    for (int r = 0; r < 12; r++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(745, 775)) : int'($urandom_range(1, 60));
      for (int i = 0; i < len; i++) fbuf[i] = 16'($urandom);
      hold_cycles = int'($urandom_range(0, 15));
      if (len > MAX_WORDS) exp_drops++;
      else exp_irqs++;
      push_frame(len, 1'b1, acc);
    end
    drain();
    check("rand_irq_count",  irq_seen - irq0,    exp_irqs);
    check("rand_drop_count", drops_seen - drop0, exp_drops);

    // Engine not idle: request withheld until i_sendIdl rises
    auto_engine = 1'b0;
    i_sendIdl = 1'b0;
    for (int i = 0; i < 40; i++) push_word(16'h5000 + 16'(i), i == 39, acc);
    repeat (8) begin
      @(negedge i_clk);
      check("idl_no_irq", 32'(o_SendIrq), 32'd0);
    end
    check("idl_busy", 32'(o_busy), 32'd1);
    i_sendIdl = 1'b1;
    @(negedge i_clk);
    check("idl_irq", 32'(o_SendIrq), 32'd1);
    check("idl_len", 32'(o_length),  32'd40);
    @(negedge i_clk);
    check("irq_one_cycle", 32'(o_SendIrq), 32'd0);
    i_data_addr = 10'd5;
    #1;
    check("idl_data5", 32'(o_data), 32'h5005);

    // Reset while waiting for done
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready",  32'(o_wr_ready), 32'd1);
    check("mid_rst_irq",    32'(o_SendIrq),  32'd0);
    check("mid_rst_length", 32'(o_length),   32'd0);
    check("mid_rst_drop",   32'(o_drop),     32'd0);
    check("mid_rst_busy",   32'(o_busy),     32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Fresh frame after reset, with last-word-to-request latency
    for (int i = 0; i < 40; i++) push_word(16'hA000 + 16'(i), i == 39, acc);
    check("lat_n1_irq", 32'(o_SendIrq), 32'd0);
    @(negedge i_clk);
    check("lat_n2_irq", 32'(o_SendIrq), 32'd1);
    check("post_rst_len", 32'(o_length), 32'd40);
    i_data_addr = 10'd0;
    #1;
    check("post_rst_data0", 32'(o_data), 32'hA000);
    i_data_addr = 10'd39;
    #1;
    check("post_rst_data39", 32'(o_data), 32'hA027);
    i_data_addr = 10'd40;
    #1;
    check("post_rst_data40", 32'(o_data), 32'h0000);
    @(negedge i_clk);
    i_sendDn = 1'b1;
    @(negedge i_clk);
    i_sendDn = 1'b0;
    check("post_rst_busy",  32'(o_busy),     32'd0);
    check("post_rst_ready", 32'(o_wr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
